// File: rtl/norm_arb_if.sv
// rtl/norm_arb_if.sv - request, normalizer and result signal bundle for norm_arb
// Purpose: groups the two requester channels, the shared normalizer hookup and
//          the result channel so norm_arb and its environment share one port.
// Ports (signals):
//   r0_*/r1_*  : requester handshake (vld/rdy) and payload (man, esum, sgn)
//   nor_i      : operand to the external normalizer
//   nor_o      : normalized fraction back from the normalizer
//   nor_bias   : normalizer bias back from the normalizer
//   o_*        : result handshake (vld/rdy), id, sgn, man, exp and status flags
// Modports: slave = norm_arb view, master = environment view.
interface norm_arb_if #(
  parameter int WIDIN  = 48,
  parameter int WIDOUT = 23,
  parameter int BIASD  = 8
) ();
  logic              r0_vld, r1_vld;
  logic              r0_rdy, r1_rdy;
  logic [WIDIN-1:0]  r0_man, r1_man;
  logic [9:0]        r0_esum, r1_esum;
  logic              r0_sgn, r1_sgn;
  logic [WIDIN-1:0]  nor_i;
  logic [WIDOUT-1:0] nor_o;
  logic [BIASD-1:0]  nor_bias;
  logic              o_vld, o_rdy;
  logic              o_id, o_sgn;
  logic [WIDOUT-1:0] o_man;
  logic [BIASD-1:0]  o_exp;
  logic              o_zero, o_ovf, o_unf;

  modport slave (
    input  r0_vld, r1_vld, r0_man, r1_man, r0_esum, r1_esum, r0_sgn, r1_sgn,
    input  nor_o, nor_bias, o_rdy,
    output r0_rdy, r1_rdy, nor_i,
    output o_vld, o_id, o_sgn, o_man, o_exp, o_zero, o_ovf, o_unf
  );

  modport master (
    output r0_vld, r1_vld, r0_man, r1_man, r0_esum, r1_esum, r0_sgn, r1_sgn,
    output nor_o, nor_bias, o_rdy,
    input  r0_rdy, r1_rdy, nor_i,
    input  o_vld, o_id, o_sgn, o_man, o_exp, o_zero, o_ovf, o_unf
  );
endinterface

// File: rtl/norm_arb.sv
// rtl/norm_arb.sv - two-requester arbiter in front of a shared mantissa normalizer
// Purpose: grants one of two requesters into a two-stage pipeline. S1 holds the
//          granted request and drives the external normalizer; S2 registers the
//          exponent/fraction result with zero/overflow/underflow mapping.
//          Fraction is truncated, never rounded up.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : norm_arb_if.slave (requesters, normalizer hookup, result channel)
// Build option: NORM_ARB_FIXPRI_EN selects fixed priority (requester 0 always
//               wins) and removes the round-robin pointer.
module norm_arb #(
  parameter int WIDIN  = 48,
  parameter int WIDOUT = 23,
  parameter int BIASD  = 8
) (
  input logic       clk,
  input logic       rst,
  norm_arb_if.slave bus
);

  logic              s1_vld;
  logic [WIDIN-1:0]  s1_man;
  logic [9:0]        s1_esum;
  logic              s1_sgn;
  logic              s1_id;

  logic              o_vld_q, o_id_q, o_sgn_q;
  logic [WIDOUT-1:0] o_man_q;
  logic [BIASD-1:0]  o_exp_q;
  logic              o_zero_q, o_ovf_q, o_unf_q;

  logic              s2_ready;
  logic              s1_acc;
  logic              gnt1;
  logic              acc;

  // S2 frees up when empty or draining; S1 can take a new request whenever
  // its current content can move on (or it is empty).
  assign s2_ready = !o_vld_q || bus.o_rdy;
  assign s1_acc   = !s1_vld || s2_ready;

`ifdef NORM_ARB_FIXPRI_EN
  assign gnt1 = bus.r1_vld && !bus.r0_vld;
`else
  // last_gnt holds the id of the most recently accepted requester; it resets
  // to 1 so that requester 0 wins the first contention.
  logic last_gnt;
  assign gnt1 = bus.r1_vld && (!bus.r0_vld || !last_gnt);
`endif

  assign bus.r0_rdy = !rst && s1_acc && bus.r0_vld && !gnt1;
  assign bus.r1_rdy = !rst && s1_acc && gnt1;
  assign acc        = bus.r0_rdy || bus.r1_rdy;

  assign bus.nor_i  = s1_vld ? s1_man : '0;

  // Signed exponent computed at 11 bits so both overflow and underflow are visible.
  logic [10:0]       e;
  logic              r_zero, r_ovf, r_unf;
  logic [BIASD-1:0]  r_exp;
  logic [WIDOUT-1:0] r_man;

  assign e = {1'b0, s1_esum} - 11'(bus.nor_bias);

  always_comb begin
    r_zero = 1'b0;
    r_ovf  = 1'b0;
    r_unf  = 1'b0;
    r_exp  = '0;
    r_man  = '0;
    if (s1_man == '0) begin
      r_zero = 1'b1;
    end else if ($signed(e) >= 11'sd255) begin
      r_ovf  = 1'b1;
      r_exp  = {BIASD{1'b1}};
    end else if ($signed(e) <= 11'sd0) begin
      r_unf  = 1'b1;
    end else begin
      r_exp  = BIASD'(e);
      r_man  = bus.nor_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_man   <= '0;
      s1_esum  <= '0;
      s1_sgn   <= 1'b0;
      s1_id    <= 1'b0;
      o_vld_q  <= 1'b0;
      o_id_q   <= 1'b0;
      o_sgn_q  <= 1'b0;
      o_man_q  <= '0;
      o_exp_q  <= '0;
      o_zero_q <= 1'b0;
      o_ovf_q  <= 1'b0;
      o_unf_q  <= 1'b0;
`ifndef NORM_ARB_FIXPRI_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      if (s1_acc) begin
        s1_vld <= acc;
        if (acc) begin
          s1_man  <= gnt1 ? bus.r1_man  : bus.r0_man;
          s1_esum <= gnt1 ? bus.r1_esum : bus.r0_esum;
          s1_sgn  <= gnt1 ? bus.r1_sgn  : bus.r0_sgn;
          s1_id   <= gnt1;
        end
      end
      // Outputs only change when S2 is free, which keeps o_* frozen under backpressure.
      if (s2_ready) begin
        o_vld_q <= s1_vld;
        if (s1_vld) begin
          o_id_q   <= s1_id;
          o_sgn_q  <= s1_sgn;
          o_man_q  <= r_man;
          o_exp_q  <= r_exp;
          o_zero_q <= r_zero;
          o_ovf_q  <= r_ovf;
          o_unf_q  <= r_unf;
        end
      end
`ifndef NORM_ARB_FIXPRI_EN
      if (acc) last_gnt <= gnt1;
`endif
    end
  end

  assign bus.o_vld  = o_vld_q;
  assign bus.o_id   = o_id_q;
  assign bus.o_sgn  = o_sgn_q;
  assign bus.o_man  = o_man_q;
  assign bus.o_exp  = o_exp_q;
  assign bus.o_zero = o_zero_q;
  assign bus.o_ovf  = o_ovf_q;
  assign bus.o_unf  = o_unf_q;

endmodule

// File: tb/tb_norm_arb.sv
// tb/tb_norm_arb.sv - scoreboard bench for norm_arb with a behavioural normalizer
module tb_norm_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  norm_arb_if #(.WIDIN(48), .WIDOUT(23), .BIASD(8)) bus ();

  norm_arb #(.WIDIN(48), .WIDOUT(23), .BIASD(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Position of the leading one, -1 for zero.
  function automatic int lead(input logic [47:0] m);
    int p = -1;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    return p;
  endfunction

  // External normalizer: bias 126 for bit 47, one more per lower bit, 174 for zero.
  always_comb begin
    int p;
    logic [47:0] sh;
    p = lead(bus.nor_i);
    sh = '0;
    if (p < 0) begin
      bus.nor_bias = 8'd174;
      bus.nor_o    = '0;
    end else begin
      bus.nor_bias = 8'(126 + 47 - p);
      sh = bus.nor_i << (47 - p);
      bus.nor_o = sh[46:24];
    end
  end

  // Expected result packed as {id, sgn, zero, ovf, unf, exp[7:0], man[22:0]}.
  function automatic logic [35:0] model(input logic [47:0] m, input logic [9:0] es,
                                        input logic s, input logic id);
    int p;
    int e;
    logic [47:0] sh;
    p = lead(m);
    if (p < 0) return {id, s, 3'b100, 8'd0, 23'd0};
    e = int'(es) - (126 + 47 - p);
    if (e >= 255) return {id, s, 3'b010, 8'd255, 23'd0};
    if (e <= 0)   return {id, s, 3'b001, 8'd0, 23'd0};
    sh = m << (47 - p);
    return {id, s, 3'b000, 8'(e), sh[46:24]};
  endfunction

  logic [35:0] sb[$];
  logic        last_g = 1'b1;
  logic        held = 1'b0;
  logic [35:0] snap;

  // Accept-side monitor: arbitration checks and scoreboard pushes.
  always @(negedge clk) begin
    if (rst) begin
      last_g = 1'b1;
    end else begin
      if (bus.r0_rdy && bus.r1_rdy) begin
        errors++;
        $display("FAIL both_rdy: r0_rdy=1 r1_rdy=1 required at most one");
      end
      if (bus.r0_vld && bus.r1_vld && (bus.r0_rdy || bus.r1_rdy)) begin
        logic expg;
`ifdef NORM_ARB_FIXPRI_EN
        expg = 1'b0;
`else
        expg = ~last_g;
`endif
        checks++;
        if (bus.r1_rdy !== expg) begin
          errors++;
          $display("FAIL grant: got %0d required %0d at cycle %0d", bus.r1_rdy, expg, cyc);
        end
      end
      if (bus.r0_vld && bus.r0_rdy) begin
        sb.push_back(model(bus.r0_man, bus.r0_esum, bus.r0_sgn, 1'b0));
        last_g = 1'b0;
      end
      if (bus.r1_vld && bus.r1_rdy) begin
        sb.push_back(model(bus.r1_man, bus.r1_esum, bus.r1_sgn, 1'b1));
        last_g = 1'b1;
      end
    end
  end

  // Output-side monitor: stability under backpressure and in-order compare.
  always @(negedge clk) begin
    logic [35:0] cur;
    logic [35:0] exp_r;
    cur = {bus.o_id, bus.o_sgn, bus.o_zero, bus.o_ovf, bus.o_unf, bus.o_exp, bus.o_man};
    if (rst) begin
      sb.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!bus.o_vld || cur !== snap) begin
          errors++;
          $display("FAIL stable: got vld=%0d %h required vld=1 %h", bus.o_vld, cur, snap);
        end
      end
      if (bus.o_vld && bus.o_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result: got %h required no result", cur);
        end else begin
          exp_r = sb.pop_front();
          if (cur !== exp_r) begin
            errors++;
            $display("FAIL result: got %h required %h", cur, exp_r);
          end
        end
        held = 1'b0;
      end else if (bus.o_vld) begin
        snap = cur;
        held = 1'b1;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic set_req(input bit id, input logic [47:0] m, input logic [9:0] es, input logic s);
    if (id) begin
      bus.r1_vld = 1'b1; bus.r1_man = m; bus.r1_esum = es; bus.r1_sgn = s;
    end else begin
      bus.r0_vld = 1'b1; bus.r0_man = m; bus.r0_esum = es; bus.r0_sgn = s;
    end
  endtask

  // Waits (bounded) for the pending request of one requester to be accepted, then drops vld.
  task automatic wait_acc(input bit id, output int acyc);
    bit ok = 0;
    acyc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (id ? (bus.r1_vld && bus.r1_rdy) : (bus.r0_vld && bus.r0_rdy)) begin
        ok = 1;
        acyc = cyc;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d got no rdy required rdy within 20 cycles", id);
    end
    @(posedge clk); #1;
    if (id) bus.r1_vld = 1'b0; else bus.r0_vld = 1'b0;
  endtask

  task automatic send(input bit id, input logic [47:0] m, input logic [9:0] es, input logic s);
    int a;
    @(posedge clk); #1;
    set_req(id, m, es, s);
    wait_acc(id, a);
  endtask

  task automatic drain();
    bus.r0_vld = 1'b0;
    bus.r1_vld = 1'b0;
    bus.o_rdy  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [47:0] rman();
    logic [63:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(7) == 0) return '0;
    return x[47:0] >> $urandom_range(47);
  endfunction

  task automatic rand_run(input int n, input int p0, input int p1, input int prdy);
    bit a0, a1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      a0 = bus.r0_vld && bus.r0_rdy;
      a1 = bus.r1_vld && bus.r1_rdy;
      @(posedge clk); #1;
      if (!bus.r0_vld || a0) begin
        if ($urandom_range(99) < p0) set_req(0, rman(), 10'($urandom_range(1023)), 1'($urandom));
        else bus.r0_vld = 1'b0;
      end
      if (!bus.r1_vld || a1) begin
        if ($urandom_range(99) < p1) set_req(1, rman(), 10'($urandom_range(1023)), 1'($urandom));
        else bus.r1_vld = 1'b0;
      end
      bus.o_rdy = ($urandom_range(99) < prdy);
    end
  endtask

  initial begin
    int a, t;
    bit seen;
    bus.r0_vld = 0; bus.r1_vld = 0; bus.o_rdy = 0;
    bus.r0_man = '0; bus.r1_man = '0; bus.r0_esum = '0; bus.r1_esum = '0;
    bus.r0_sgn = 0; bus.r1_sgn = 0;

    // Reset state, with requests pending so rdy-held-low is meaningful.
    rst = 1'b1;
    bus.r0_vld = 1'b1; bus.r1_vld = 1'b1; bus.o_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", {62'd0, bus.r0_rdy, bus.r1_rdy}, 64'd0);
    check("rst_out", 64'({bus.o_vld, bus.o_id, bus.o_sgn, bus.o_zero, bus.o_ovf,
                          bus.o_unf, bus.o_exp, bus.o_man}), 64'd0);
    bus.r0_vld = 1'b0; bus.r1_vld = 1'b0;
    rst = 1'b0;

    // Directed: bit 47, esum 254 -> exp 128, two-cycle latency.
    @(posedge clk); #1;
    set_req(0, 48'h8000_0000_0000, 10'd254, 1'b1);
    wait_acc(0, a);
    seen = 0;
    t = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_vld) begin seen = 1; t = cyc - a; end
    end
    check("latency", 64'(t), 64'd2);
    check("d036_out", 64'({bus.o_id, bus.o_sgn, bus.o_zero, bus.o_ovf, bus.o_unf, bus.o_exp, bus.o_man}),
          64'({1'b0, 1'b1, 3'b000, 8'd128, 23'd0}));

    // Directed zero / overflow / underflow.
    send(1, 48'h0, 10'd200, 1'b0);
    send(0, 48'h8000_0000_0000, 10'd400, 1'b0);
    send(1, 48'h4000_0000_0000, 10'd100, 1'b1);
    drain();

    // Both requesters held valid with o_rdy high: strict alternation, one per cycle.
    rand_run(30, 100, 100, 100);
    drain();

    // Backpressure: two in flight, third pending stalls for 3 cycles.
    @(posedge clk); #1;
    bus.o_rdy = 1'b0;
    send(0, 48'h1234_5678_9abc, 10'd300, 1'b0);
    send(1, 48'h0000_ffff_0000, 10'd250, 1'b1);
    set_req(0, 48'h0fff_0000_0001, 10'd180, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rdy", {62'd0, bus.r0_rdy, bus.r1_rdy}, 64'd0);
    end
    @(posedge clk); #1;
    bus.o_rdy = 1'b1;
    wait_acc(0, a);
    drain();

    // Random mixed traffic with random backpressure.
    rand_run(400, 60, 60, 70);
    drain();

    // Reset with S1 and S2 full; r0 must win the first contention afterwards.
    @(posedge clk); #1;
    bus.o_rdy = 1'b0;
    send(1, 48'h0000_0001_0000, 10'd220, 1'b0);
    send(1, 48'h0000_0000_0100, 10'd210, 1'b1);
    set_req(0, 48'h8000_0000_0001, 10'd200, 1'b0);
    set_req(1, 48'h0400_0000_0000, 10'd190, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_vld", 64'(bus.o_vld), 64'd0);
    check("rst_mid_rdy", {62'd0, bus.r0_rdy, bus.r1_rdy}, 64'd0);
    rst = 1'b0;
    bus.o_rdy = 1'b1;
    @(negedge clk);
    check("post_rst_grant", {62'd0, bus.r0_rdy, bus.r1_rdy}, 64'b10);
    @(posedge clk); #1;
    bus.r0_vld = 1'b0;
    wait_acc(1, a);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
